spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
- Receive-side stage directly downstream of the team's 12-bit SPI master.
- Consumes the master's cs, sclk and mosi, and reassembles each frame into a DATA_W-bit word.
- Buffers completed words in a small FIFO and presents them on a valid/ready interface to the system-clock consumer.
- Runs on the master's system clock and oversamples the SPI lines. It does not use sclk as a clock.

Parameters:
- DATA_W, 12: bits per SPI frame. Matches the master's din width.
- LSB_FIRST, 1: 1 means the first received bit is word[0]; 0 means the first received bit is word[DATA_W-1].
- FIFO_DEPTH, 4: number of output word buffer entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock. Same clock that drives the SPI master.
- rst_n  in  1  reset. Synchronous, active-low.
- cs  in  1  SPI chip select from the master, active-low.
- sclk  in  1  SPI serial clock from the master, idle low.
- mosi  in  1  SPI serial data from the master.
- out_data  out  DATA_W  word at the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head word when out_valid && out_ready at a clk edge.
- frame_err  out  1  one-cycle pulse: protocol error.
- overflow  out  1  one-cycle pulse: completed word dropped because the FIFO was full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset, at a clk edge with rst_n=0:
  - FSM goes to IDLE; bit_cnt=0; shift register=0; FIFO pointers and count = 0.
  - Outputs: out_valid=0, out_data=0, frame_err=0, overflow=0, fifo_count=0.
  - Synchronizer flops reset to cs=1, sclk=0, mosi=0.
- Input conditioning:
  - cs, sclk and mosi each pass through a 2-flop synchronizer; the synchronized versions are cs_s, sclk_s, mosi_s.
  - sclk_rise = sclk_s & ~sclk_q, where sclk_q is a 1-flop delay of sclk_s. cs_fall and cs_rise are derived the same way.
  - sclk high and low phases must each last at least 2 clk periods. The master satisfies this.
- Sampling: mosi_s is sampled on sclk_rise. The master changes mosi away from the sclk rising edge.
- FSM states:
  - IDLE:
    - cs_fall -> SHIFT, with bit_cnt=0.
    - sclk_rise while in IDLE is ignored.
  - SHIFT:
    - On sclk_rise, shift in mosi_s and increment bit_cnt.
    - With LSB_FIRST=1, shift right: new bit enters the MSB, so after DATA_W bits the first-received bit sits at [0].
    - With LSB_FIRST=0, shift left: new bit enters the LSB.
    - When the DATA_W-th bit is sampled, push the assembled word (including that bit) into the FIFO in the same cycle, then -> DONE_WAIT.
    - cs_rise before DATA_W bits -> frame_err pulse, discard the partial word, -> IDLE.
  - DONE_WAIT:
    - cs_rise -> IDLE.
    - Any sclk_rise -> frame_err pulse; the bit is ignored and the state is held.
  - If cs_rise and the final sclk_rise occur in the same cycle, the word completes normally. Ordering: push, then -> IDLE, no error.
- FIFO:
  - Push with count==FIFO_DEPTH and no pop in the same cycle -> word dropped, overflow pulses 1 cycle.
  - Push and pop in the same cycle when full -> both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle when empty is impossible, because out_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data shows the head entry. It holds when out_valid=0 or out_ready=0.
- Latency:
  - Let N be the clk edge at which the raw final-bit sclk rise is first captured in the synchronizer.
  - FIFO write happens at edge N+2. out_valid is high in the cycle after N+2 if the FIFO was previously empty.
- Reset mid-frame: the partial word is discarded. Because cs_s resets to 1, a cs held low through reset produces a cs_fall once the synchronizer refills. That partial frame then arms SHIFT and produces frame_err on its cs_rise; this is accepted behaviour.
- frame_err and overflow may pulse in the same cycle.

Decomposition:
- Shared package spi_pkg:
  - SPI_DATA_W = 12.
  - FSM state enum: IDLE, SHIFT, DONE_WAIT.
  - Synchronizer reset values.
- One sub-module, sync_fifo, parameterized by width and depth, with push/pop/full/empty/count. spi_slave_rx instantiates it once.
- The synchronizers and edge detectors stay inline.

Test Plan:
- Single frame: master sends din=12'h0A5 (LSB first), out_ready=1 -> exactly one out_valid cycle with out_data=12'h0A5; frame_err=0; fifo_count returns to 0.
- Burst: master sends 0x00A, 0x0C8, 0x07F, 0x001, 0x0B4 with out_ready=0 -> fifo_count reaches 4 after the 4th frame; overflow pulses once on the 5th frame; then out_ready=1 drains in order 0x00A, 0x0C8, 0x07F, 0x001.
- Short frame: drive cs low, 7 sclk pulses, cs high -> frame_err pulses once; no push. A following full frame 0x123 is received correctly.
- Extra clock: 12 bits of 0x3C3 plus a 13th sclk pulse before cs rises -> word 0x3C3 pushed; frame_err pulses once on the 13th pulse.
- Full plus simultaneous pop: FIFO full, out_ready=1 held so that a pop coincides with the push of 0x0FF -> no overflow; 0x0FF appears after the 3 older words.
- Reset mid-frame: rst_n=0 for 2 cycles after 6 bits, cs held low, then cs high and a new frame 0x055 -> no stale data; 0x055 received; all outputs 0 during reset.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive path: frame width, FSM states, synchronizer reset levels.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spi_pkg;

   localparam int SPI_DATA_W = 12;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SHIFT     = 2'd1,
      DONE_WAIT = 2'd2
   } state_t;

   // Synchronizer reset levels: the bus looks idle (deselected, clock low) out of reset.
   localparam logic SYNC_CS_RST   = 1'b1;
   localparam logic SYNC_SCLK_RST = 1'b0;
   localparam logic SYNC_MOSI_RST = 1'b0;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Bundle of SPI lines in and the received-word stream out of spi_slave_rx.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer; the SPI side has none.
// Signals: cs/sclk/mosi (SPI in), out_data/out_valid/out_ready (word stream),
//          frame_err/overflow (one-cycle status pulses), fifo_count (occupancy).
interface spi_slave_rx_if #(
   parameter int DATA_W     = spi_pkg::SPI_DATA_W,
   parameter int FIFO_DEPTH = 4
);
   import spi_pkg::*;

   logic                        cs;
   logic                        sclk;
   logic                        mosi;
   logic [DATA_W-1:0]           out_data;
   logic                        out_valid;
   logic                        out_ready;
   logic                        frame_err;
   logic                        overflow;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   // The receiver block.
   modport slave (
      input  cs, sclk, mosi, out_ready,
      output out_data, out_valid, frame_err, overflow, fifo_count
   );

   // The environment: SPI master plus word consumer.
   modport master (
      output cs, sclk, mosi, out_ready,
      input  out_data, out_valid, frame_err, overflow, fifo_count
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and occupancy count.
// Latency: a push is visible at the head (empty deasserts) the cycle after the write edge.
// Backpressure: push while full without a pop is ignored; push and pop together when full both succeed.
// Ports: clk, rst_n (sync, active-low), push/push_data, pop, rd_data (head), full, empty, count.
module sync_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr).
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spi_slave_rx.sv
// Oversampling SPI receiver: reassembles cs/sclk/mosi frames into words and queues them for a valid/ready consumer.
// Latency: final-bit sclk rise captured at edge N -> FIFO write at edge N+2 -> out_valid the cycle after.
// Backpressure: out_ready stalls the FIFO; a word completing while the FIFO is full is dropped with an overflow pulse.
// Ports: clk, rst_n (sync, active-low), bus (slave modport: cs/sclk/mosi in, out_* stream, frame_err, overflow, fifo_count).
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int DATA_W     = SPI_DATA_W,
   parameter int LSB_FIRST  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   spi_slave_rx_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_W) + 1;

   // Two-flop synchronizers plus one extra delay flop for edge detection.
   logic cs_m, cs_s, cs_q;
   logic sclk_m, sclk_s, sclk_q;
   logic mosi_m, mosi_s;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cs_m   <= SYNC_CS_RST;
         cs_s   <= SYNC_CS_RST;
         cs_q   <= SYNC_CS_RST;
         sclk_m <= SYNC_SCLK_RST;
         sclk_s <= SYNC_SCLK_RST;
         sclk_q <= SYNC_SCLK_RST;
         mosi_m <= SYNC_MOSI_RST;
         mosi_s <= SYNC_MOSI_RST;
      end else begin
         cs_m   <= bus.cs;
         cs_s   <= cs_m;
         cs_q   <= cs_s;
         sclk_m <= bus.sclk;
         sclk_s <= sclk_m;
         sclk_q <= sclk_s;
         mosi_m <= bus.mosi;
         mosi_s <= mosi_m;
      end
   end

   logic sclk_rise, cs_fall, cs_rise;
   assign sclk_rise = sclk_s & ~sclk_q;
   assign cs_fall   = ~cs_s & cs_q;
   assign cs_rise   = cs_s & ~cs_q;

   state_t            state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] sr;
   logic [DATA_W-1:0] shifted;
   logic              last_bit;
   logic              push;
   logic              frame_err_r;

   // Register contents after taking mosi_s; for the final bit this is the complete word.
   always_comb begin
      shifted = sr;
      if (LSB_FIRST != 0) begin
         shifted = {mosi_s, sr[DATA_W-1:1]};
      end else begin
         shifted = {sr[DATA_W-2:0], mosi_s};
      end
   end

   assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
   // Push is combinational so the word enters the FIFO on the same edge its last bit is sampled.
   assign push     = (state == SHIFT) & sclk_rise & last_bit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         sr          <= '0;
         frame_err_r <= 1'b0;
      end else begin
         frame_err_r <= 1'b0;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
                  sr      <= '0;
               end
            end
            SHIFT: begin
               if (push) begin
                  // A coincident cs_rise still completes the word cleanly.
                  bit_cnt <= '0;
                  sr      <= '0;
                  state   <= cs_rise ? IDLE : DONE_WAIT;
               end else if (cs_rise) begin
                  frame_err_r <= 1'b1;
                  bit_cnt     <= '0;
                  sr          <= '0;
                  state       <= IDLE;
               end else if (sclk_rise) begin
                  sr      <= shifted;
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            DONE_WAIT: begin
               if (sclk_rise) begin
                  frame_err_r <= 1'b1;
               end
               if (cs_rise) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic fifo_full, fifo_empty, pop, overflow_r;

   assign pop = ~fifo_empty & bus.out_ready;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (shifted),
      .pop       (pop),
      .rd_data   (bus.out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (bus.fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= push & fifo_full & ~pop;
      end
   end

   assign bus.out_valid = ~fifo_empty;
   assign bus.frame_err = frame_err_r;
   assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed protocol scenarios followed by random frames against a word-queue model.
// Latency: n/a.
// Backpressure: out_ready driven by the bench (held, pulsed, or randomized).
module tb_spi_slave_rx;
   import spi_pkg::*;

   localparam int DW = 12;

   logic clk;
   logic rst_n;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   spi_slave_rx_if #(.DATA_W(DW), .FIFO_DEPTH(4)) bus ();

   spi_slave_rx #(
      .DATA_W     (DW),
      .LSB_FIRST  (1),
      .FIFO_DEPTH (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Monitor: sample away from the active edge; a handshake seen here completes on the next posedge.
   int err_cnt    = 0;
   int ovf_cnt    = 0;
   int vld_cycles = 0;
   int got_q[$];

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.frame_err) err_cnt++;
         if (bus.overflow)  ovf_cnt++;
         if (bus.out_valid) vld_cycles++;
         if (bus.out_valid && bus.out_ready) got_q.push_back(int'(bus.out_data));
      end
   end

   bit rnd_mode = 1'b0;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_mode) bus.out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic cs_low();
      bus.cs = 1'b0;
      ticks(4);
   endtask

   task automatic cs_high();
      ticks(3);
      bus.cs = 1'b1;
      ticks(6);
   endtask

   // One SPI bit: mosi set with sclk low, 2 cycles low, 3 cycles high.
   // With pop_last, out_ready is high exactly for the cycle ending at the receiver's push edge.
   task automatic sbit(input logic b, input bit pop_last);
      bus.mosi = b;
      ticks(2);
      bus.sclk = 1'b1;
      tick();
      tick();
      if (pop_last) bus.out_ready = 1'b1;
      tick();
      if (pop_last) bus.out_ready = 1'b0;
      bus.sclk = 1'b0;
   endtask

   // Frame as the master sends it: LSB first, nbits clock pulses.
   task automatic frame(input int w, input int nbits, input bit pop_last);
      cs_low();
      for (int i = 0; i < nbits; i++) begin
         sbit(1'(w >> i), pop_last && (i == nbits - 1));
      end
      cs_high();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, int'(bus.out_valid), 0);
      check({tag, "_data"},  int'(bus.out_data), 0);
      check({tag, "_err"},   int'(bus.frame_err), 0);
      check({tag, "_ovf"},   int'(bus.overflow), 0);
      check({tag, "_count"}, int'(bus.fifo_count), 0);
   endtask

   initial begin
      int g0, e0, o0, v0, nshort, w, n;
      int burst[5];
      int fullpop[5];
      int exp_q[$];

      burst   = '{32'h00A, 32'h0C8, 32'h07F, 32'h001, 32'h0B4};
      fullpop = '{32'h011, 32'h022, 32'h033, 32'h044, 32'h0FF};

      bus.cs        = 1'b1;
      bus.sclk      = 1'b0;
      bus.mosi      = 1'b0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      ticks(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      ticks(4);

      // Single frame with the consumer always ready.
      bus.out_ready = 1'b1;
      g0 = got_q.size(); e0 = err_cnt; v0 = vld_cycles;
      frame(32'h0A5, DW, 1'b0);
      ticks(4);
      check("single_n", got_q.size() - g0, 1);
      if (got_q.size() > g0) check("single_data", got_q[g0], 32'h0A5);
      check("single_vld_cycles", vld_cycles - v0, 1);
      check("single_err", err_cnt - e0, 0);
      check("single_count", int'(bus.fifo_count), 0);

      // Burst into a stalled consumer: 4 fit, the 5th overflows.
      bus.out_ready = 1'b0;
      o0 = ovf_cnt;
      for (int i = 0; i < 4; i++) frame(burst[i], DW, 1'b0);
      check("burst_count4", int'(bus.fifo_count), 4);
      check("burst_no_ovf", ovf_cnt - o0, 0);
      frame(burst[4], DW, 1'b0);
      check("burst_ovf", ovf_cnt - o0, 1);
      check("burst_count_full", int'(bus.fifo_count), 4);
      g0 = got_q.size();
      bus.out_ready = 1'b1;
      ticks(8);
      check("burst_drain_n", got_q.size() - g0, 4);
      for (int i = 0; i < 4; i++) begin
         if (got_q.size() > g0 + i) check($sformatf("burst_word%0d", i), got_q[g0 + i], burst[i]);
      end
      check("burst_empty", int'(bus.out_valid), 0);

      // Short frame: 7 pulses then deselect.
      g0 = got_q.size(); e0 = err_cnt;
      frame(32'h07F, 7, 1'b0);
      ticks(2);
      check("short_err", err_cnt - e0, 1);
      check("short_no_push", got_q.size() - g0, 0);
      frame(32'h123, DW, 1'b0);
      ticks(4);
      check("after_short_n", got_q.size() - g0, 1);
      if (got_q.size() > g0) check("after_short_data", got_q[g0], 32'h123);
      check("after_short_err", err_cnt - e0, 1);

      // Extra 13th clock pulse after a complete word.
      g0 = got_q.size(); e0 = err_cnt;
      frame(32'h3C3, DW + 1, 1'b0);
      ticks(4);
      check("extra_n", got_q.size() - g0, 1);
      if (got_q.size() > g0) check("extra_data", got_q[g0], 32'h3C3);
      check("extra_err", err_cnt - e0, 1);

      // Full FIFO with a pop landing on the push edge of the new word.
      bus.out_ready = 1'b0;
      g0 = got_q.size(); o0 = ovf_cnt;
      for (int i = 0; i < 4; i++) frame(fullpop[i], DW, 1'b0);
      check("fullpop_count4", int'(bus.fifo_count), 4);
      frame(fullpop[4], DW, 1'b1);
      check("fullpop_no_ovf", ovf_cnt - o0, 0);
      check("fullpop_count", int'(bus.fifo_count), 4);
      bus.out_ready = 1'b1;
      ticks(8);
      check("fullpop_n", got_q.size() - g0, 5);
      for (int i = 0; i < 5; i++) begin
         if (got_q.size() > g0 + i) check($sformatf("fullpop_word%0d", i), got_q[g0 + i], fullpop[i]);
      end

      // Reset in the middle of a frame, cs held low through it.
      cs_low();
      for (int i = 0; i < 6; i++) sbit(1'(32'h2AA >> i), 1'b0);
      rst_n = 1'b0;
      tick();
      check_reset_outputs("midrst1");
      tick();
      check_reset_outputs("midrst2");
      rst_n = 1'b1;
      tick();
      bus.cs = 1'b1;
      ticks(10);
      g0 = got_q.size();
      frame(32'h055, DW, 1'b0);
      ticks(4);
      check("postrst_n", got_q.size() - g0, 1);
      if (got_q.size() > g0) check("postrst_data", got_q[g0], 32'h055);

      // Random frames with a random-stall consumer; model is the ordered list of complete words.
      g0 = got_q.size(); e0 = err_cnt; o0 = ovf_cnt; nshort = 0;
      rnd_mode = 1'b1;
      for (int k = 0; k < 24; k++) begin
         w = int'($urandom_range(0, 4095));
         if ($urandom_range(0, 3) == 0) begin
            n = int'($urandom_range(1, DW - 1));
            nshort++;
         end else begin
            n = DW;
            exp_q.push_back(w);
         end
         frame(w, n, 1'b0);
      end
      rnd_mode = 1'b0;
      bus.out_ready = 1'b1;
      ticks(10);
      check("rand_n", got_q.size() - g0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (got_q.size() > g0 + i) check($sformatf("rand_word%0d", i), got_q[g0 + i], exp_q[i]);
      end
      check("rand_err", err_cnt - e0, nshort);
      check("rand_ovf", ovf_cnt - o0, 0);
      check("rand_count", int'(bus.fifo_count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
